// File: rtl/apb_fsm_controller.sv
// -----------------------------------------------------------------------------
// apb_fsm_controller
//
// APB master-side state machine of the AHB-to-APB bridge. Accepts transfer
// requests from the AHB slave interface, runs the APB setup/access sequence
// towards a zero-wait-state APB slave, stretches the AHB data phase through
// hready_out, and returns read data on hrdata.
//
// Ports:
//   hclk        bridge clock, all state on the rising edge
//   hresetn     asynchronous active-low reset
//   valid       AHB address phase carries a NONSEQ/SEQ transfer
//   hwrite      address-phase direction (1 = write)
//   haddr       address-phase address
//   tempselx    one-hot peripheral select (3'b000 = no slave)
//   hwdata      write data, valid in the write data phase
//   prdata      read data from the APB interface stage
//   pwrite      APB direction
//   penable     APB enable (access phase)
//   pselx       APB one-hot select
//   paddr       APB address
//   pwdata      APB write data
//   hready_out  AHB ready, 0 inserts a wait state
//   hrdata      AHB read data
// -----------------------------------------------------------------------------
module apb_fsm_controller #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  valid,
  input  logic                  hwrite,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [2:0]            tempselx,
  input  logic [DATA_WIDTH-1:0] hwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  output logic                  pwrite,
  output logic                  penable,
  output logic [2:0]            pselx,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  output logic                  hready_out,
  output logic [DATA_WIDTH-1:0] hrdata
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_READ    = 3'd1;
  localparam logic [2:0] ST_RENABLE = 3'd2;
  localparam logic [2:0] ST_WWAIT   = 3'd3;
  localparam logic [2:0] ST_WRITE   = 3'd4;
  localparam logic [2:0] ST_WENABLE = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
  logic [2:0]            sel_q,   sel_d;
  logic                  dir_q,   dir_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic accept;
  logic can_accept;
  logic sel_active;
  logic access_phase;
  logic write_phase;

  // ---------------------------------------------------------------------------
  // Output decode: everything except hrdata comes from registers only, so the
  // AHB side never sees a combinational path from its own inputs.
  // ---------------------------------------------------------------------------
  always_comb begin
    hready_out   = 1'b1;
    sel_active   = 1'b0;
    access_phase = 1'b0;
    write_phase  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        hready_out = 1'b1;
      end
      ST_READ: begin
        hready_out = 1'b0;
        sel_active = 1'b1;
      end
      ST_RENABLE: begin
        hready_out   = 1'b1;
        sel_active   = 1'b1;
        access_phase = 1'b1;
      end
      ST_WWAIT: begin
        hready_out = 1'b0;
      end
      ST_WRITE: begin
        hready_out  = 1'b0;
        sel_active  = 1'b1;
        write_phase = 1'b1;
      end
      ST_WENABLE: begin
        hready_out   = 1'b1;
        sel_active   = 1'b1;
        access_phase = 1'b1;
        write_phase  = 1'b1;
      end
      default: begin
        hready_out = 1'b1;
      end
    endcase
  end

  // Each select line is gated individually by the "in an APB cycle" decode.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_psel
      assign pselx[gi] = sel_active & sel_q[gi];
    end
  endgenerate

  assign penable = access_phase;
  // dir_q is only ever 1 for transfers routed through the write states; the
  // AND keeps pwrite tied to the captured direction as a consistency guard.
  assign pwrite  = write_phase & dir_q;
  // paddr/pwdata are straight from the capture registers so they hold their
  // last value while the bus is idle.
  assign paddr   = addr_q;
  assign pwdata  = wdata_q;
  // The only input-to-output combinational path in the block.
  assign hrdata  = (state_q == ST_RENABLE) ? prdata : '0;

  // ---------------------------------------------------------------------------
  // Acceptance: only in states that present hready_out=1 to the AHB master.
  // An unmapped access (tempselx==0) never starts an APB cycle.
  // ---------------------------------------------------------------------------
  assign can_accept = (state_q == ST_IDLE) || (state_q == ST_RENABLE) ||
                      (state_q == ST_WENABLE);
  assign accept     = can_accept & hready_out & valid & (tempselx != 3'b000);

  // ---------------------------------------------------------------------------
  // Next-state and capture logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    dir_d   = dir_q;
    wdata_d = wdata_q;

    if (accept) begin
      addr_d = haddr;
      sel_d  = tempselx;
      dir_d  = hwrite;
    end

    case (state_q)
      ST_IDLE, ST_RENABLE, ST_WENABLE: begin
        if (accept) begin
          state_d = hwrite ? ST_WWAIT : ST_READ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        state_d = ST_RENABLE;
      end
      ST_WWAIT: begin
        // Write data only becomes valid in the AHB data phase, one cycle
        // after the address was accepted.
        wdata_d = hwdata;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        state_d = ST_WENABLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      sel_q   <= '0;
      dir_q   <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      dir_q   <= dir_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: tb/tb_apb_fsm_controller.sv
// -----------------------------------------------------------------------------
// Directed testbench for apb_fsm_controller: reset, single read, single write,
// back-to-back read-then-write, address hold during wait, reset mid-transfer,
// and unmapped accesses.
// -----------------------------------------------------------------------------
module tb_apb_fsm_controller;

  logic        hclk;
  logic        hresetn;
  logic        valid;
  logic        hwrite;
  logic [31:0] haddr;
  logic [2:0]  tempselx;
  logic [31:0] hwdata;
  logic [31:0] prdata;
  logic        pwrite;
  logic        penable;
  logic [2:0]  pselx;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        hready_out;
  logic [31:0] hrdata;

  int checks;
  int failures;

  apb_fsm_controller #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32)
  ) dut (
    .hclk       (hclk),
    .hresetn    (hresetn),
    .valid      (valid),
    .hwrite     (hwrite),
    .haddr      (haddr),
    .tempselx   (tempselx),
    .hwdata     (hwdata),
    .prdata     (prdata),
    .pwrite     (pwrite),
    .penable    (penable),
    .pselx      (pselx),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .hready_out (hready_out),
    .hrdata     (hrdata)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic chk_apb(input string tag, input logic [2:0] sel, input logic en,
                         input logic wr, input logic rdy);
    chk({tag, ".pselx"},      {29'd0, pselx},      {29'd0, sel});
    chk({tag, ".penable"},    {31'd0, penable},    {31'd0, en});
    chk({tag, ".pwrite"},     {31'd0, pwrite},     {31'd0, wr});
    chk({tag, ".hready_out"}, {31'd0, hready_out}, {31'd0, rdy});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    hresetn  = 1'b0;
    valid    = 1'b0;
    hwrite   = 1'b0;
    haddr    = 32'h0;
    tempselx = 3'b000;
    hwdata   = 32'h0;
    prdata   = 32'h0;

    // ---- reset values ----
    #12;
    chk_apb("rst", 3'b000, 1'b0, 1'b0, 1'b1);
    chk("rst.paddr",  paddr,  32'h0);
    chk("rst.pwdata", pwdata, 32'h0);
    chk("rst.hrdata", hrdata, 32'h0);
    @(negedge hclk);
    hresetn = 1'b1;

    // ---- single read ----
    valid = 1'b1; hwrite = 1'b0; haddr = 32'h8000_0010; tempselx = 3'b001;
    prdata = 32'h19;
    step();  // ST_READ
    $display("read setup  : psel=%b en=%b rdy=%b paddr=%h", pselx, penable, hready_out, paddr);
    chk_apb("rd.setup", 3'b001, 1'b0, 1'b0, 1'b0);
    chk("rd.setup.paddr",  paddr,  32'h8000_0010);
    chk("rd.setup.hrdata", hrdata, 32'h0);
    valid = 1'b0;
    step();  // ST_RENABLE
    $display("read access : psel=%b en=%b rdy=%b hrdata=%h", pselx, penable, hready_out, hrdata);
    chk_apb("rd.access", 3'b001, 1'b1, 1'b0, 1'b1);
    chk("rd.access.hrdata", hrdata, 32'h19);
    chk("rd.access.paddr",  paddr,  32'h8000_0010);
    step();  // ST_IDLE
    chk_apb("rd.done", 3'b000, 1'b0, 1'b0, 1'b1);
    chk("rd.done.hrdata", hrdata, 32'h0);

    // ---- single write, with haddr changed during the wait states ----
    valid = 1'b1; hwrite = 1'b1; haddr = 32'h8400_0004; tempselx = 3'b010;
    step();  // ST_WWAIT
    chk_apb("wr.wait", 3'b000, 1'b0, 1'b0, 1'b0);
    hwdata = 32'hDEAD_BEEF;
    haddr  = 32'h1234_5678;
    step();  // ST_WRITE
    $display("write setup : psel=%b en=%b wr=%b rdy=%b paddr=%h pwdata=%h",
             pselx, penable, pwrite, hready_out, paddr, pwdata);
    chk_apb("wr.setup", 3'b010, 1'b0, 1'b1, 1'b0);
    chk("wr.setup.paddr",  paddr,  32'h8400_0004);
    chk("wr.setup.pwdata", pwdata, 32'hDEAD_BEEF);
    valid = 1'b0; hwdata = 32'h0;
    step();  // ST_WENABLE
    $display("write access: psel=%b en=%b wr=%b rdy=%b paddr=%h pwdata=%h",
             pselx, penable, pwrite, hready_out, paddr, pwdata);
    chk_apb("wr.access", 3'b010, 1'b1, 1'b1, 1'b1);
    chk("wr.access.paddr",  paddr,  32'h8400_0004);
    chk("wr.access.pwdata", pwdata, 32'hDEAD_BEEF);
    step();  // ST_IDLE, paddr/pwdata hold
    chk_apb("wr.done", 3'b000, 1'b0, 1'b0, 1'b1);
    chk("wr.done.paddr_hold",  paddr,  32'h8400_0004);
    chk("wr.done.pwdata_hold", pwdata, 32'hDEAD_BEEF);

    // ---- back-to-back read then write ----
    valid = 1'b1; hwrite = 1'b0; haddr = 32'h8000_0020; tempselx = 3'b100;
    prdata = 32'h55;
    step();  // ST_READ
    chk_apb("b2b.rsetup", 3'b100, 1'b0, 1'b0, 1'b0);
    // Present the write now; it must be ignored while hready_out=0 and taken
    // at the end of the access cycle.
    hwrite = 1'b1; haddr = 32'h8800_0008; tempselx = 3'b001;
    step();  // ST_RENABLE
    $display("b2b read    : psel=%b en=%b rdy=%b paddr=%h hrdata=%h",
             pselx, penable, hready_out, paddr, hrdata);
    chk_apb("b2b.raccess", 3'b100, 1'b1, 1'b0, 1'b1);
    chk("b2b.raccess.paddr",  paddr,  32'h8000_0020);
    chk("b2b.raccess.hrdata", hrdata, 32'h55);
    step();  // ST_WWAIT (not ST_IDLE: hready_out low)
    chk_apb("b2b.wwait", 3'b000, 1'b0, 1'b0, 1'b0);
    chk("b2b.wwait.hrdata", hrdata, 32'h0);
    hwdata = 32'hCAFE_F00D; valid = 1'b0;
    step();  // ST_WRITE
    chk_apb("b2b.wsetup", 3'b001, 1'b0, 1'b1, 1'b0);
    chk("b2b.wsetup.paddr",  paddr,  32'h8800_0008);
    chk("b2b.wsetup.pwdata", pwdata, 32'hCAFE_F00D);
    step();  // ST_WENABLE
    chk_apb("b2b.waccess", 3'b001, 1'b1, 1'b1, 1'b1);

    // ---- reset asserted in ST_WENABLE ----
    #2;
    hresetn = 1'b0;
    #1;
    $display("mid reset   : psel=%b en=%b rdy=%b paddr=%h", pselx, penable, hready_out, paddr);
    chk_apb("midrst", 3'b000, 1'b0, 1'b0, 1'b1);
    chk("midrst.paddr",  paddr,  32'h0);
    chk("midrst.pwdata", pwdata, 32'h0);
    @(negedge hclk);
    hresetn = 1'b1;
    step();
    chk_apb("midrst.idle", 3'b000, 1'b0, 1'b0, 1'b1);

    // ---- unmapped address: never leaves ST_IDLE ----
    valid = 1'b1; hwrite = 1'b0; haddr = 32'h9000_0000; tempselx = 3'b000;
    for (int i = 0; i < 3; i++) begin
      step();
      $display("unmapped %0d  : psel=%b en=%b rdy=%b", i, pselx, penable, hready_out);
      chk_apb("unmapped", 3'b000, 1'b0, 1'b0, 1'b1);
      chk("unmapped.paddr", paddr, 32'h0);
    end

    // ---- a mapped write right after, from ST_IDLE ----
    hwrite = 1'b1; tempselx = 3'b100; haddr = 32'h8000_0100;
    step();
    chk_apb("post.wwait", 3'b000, 1'b0, 1'b0, 1'b0);
    valid = 1'b0; hwdata = 32'h0000_A5A5;
    step();
    chk_apb("post.wsetup", 3'b100, 1'b0, 1'b1, 1'b0);
    chk("post.wsetup.pwdata", pwdata, 32'h0000_A5A5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_fsm_controller.md
# apb_fsm_controller

APB master-side state machine of the AHB-to-APB bridge. It takes transfer requests from the AHB slave interface and generates the APB phase sequence (pselx, penable, pwrite, paddr, pwdata). These outputs drive the downstream APB interface stage. It also stretches the AHB data phase through hready_out and returns read data on hrdata.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width of haddr/paddr
- DATA_WIDTH, 32, data width of hwdata/pwdata/prdata/hrdata

Ports:
- hclk  input  1  bridge clock, all state on rising edge
- hresetn  input  1  reset, asynchronous and active-low
- valid  input  1  AHB address phase carries a NONSEQ/SEQ transfer to the bridge
- hwrite  input  1  address-phase direction, 1 = write
- haddr  input  ADDR_WIDTH  address-phase address
- tempselx  input  3  one-hot peripheral select decoded from haddr; 3'b000 = no slave
- hwdata  input  DATA_WIDTH  write data, valid in the write data phase
- prdata  input  DATA_WIDTH  read data from the APB interface stage
- pwrite  output  1  APB direction
- penable  output  1  APB enable (access phase)
- pselx  output  3  APB one-hot select
- paddr  output  ADDR_WIDTH  APB address
- pwdata  output  DATA_WIDTH  APB write data
- hready_out  output  1  AHB ready; 0 inserts a wait state
- hrdata  output  DATA_WIDTH  AHB read data

## Operation
- Request acceptance:
  - A request is accepted on a rising edge where hready_out=1, valid=1 and tempselx!=0.
  - On acceptance, haddr→addr_reg, tempselx→sel_reg and hwrite→dir_reg are captured.
  - valid with tempselx=0 is ignored and no APB cycle occurs.
- States: ST_IDLE, ST_READ, ST_RENABLE, ST_WWAIT, ST_WRITE, ST_WENABLE.
- ST_IDLE:
  - hready_out=1.
  - Accepted read → ST_READ; accepted write → ST_WWAIT; otherwise stay.
- ST_READ (setup):
  - pselx=sel_reg, penable=0, pwrite=0, paddr=addr_reg, hready_out=0.
  - Always → ST_RENABLE.
- ST_RENABLE (access):
  - pselx=sel_reg, penable=1, pwrite=0, hready_out=1, hrdata=prdata.
  - Next state follows the ST_IDLE acceptance rules (back-to-back transfers allowed).
- ST_WWAIT:
  - hready_out=0, pselx=0.
  - hwdata→wdata_reg.
  - Always → ST_WRITE.
- ST_WRITE (setup):
  - pselx=sel_reg, penable=0, pwrite=1, paddr=addr_reg, pwdata=wdata_reg, hready_out=0.
  - Always → ST_WENABLE.
- ST_WENABLE (access):
  - Same as ST_WRITE except penable=1 and hready_out=1.
  - Next state follows the ST_IDLE acceptance rules.
- Output sourcing:
  - APB outputs and hready_out decode from the state register and capture registers only.
  - The only input-to-output combinational path is prdata→hrdata.
  - hrdata=0 outside ST_RENABLE.
- Idle output values:
  - In ST_IDLE and ST_WWAIT: pselx=0, penable=0, pwrite=0.
  - paddr and pwdata hold their last registered value.
- The APB slave is zero-wait-state; pready is not supported.

## Timing
- Reset values (asserted asynchronously, released synchronously to hclk):
  - state=ST_IDLE, hready_out=1, pselx=0, penable=0, pwrite=0, paddr=0, pwdata=0, hrdata=0.
  - All capture registers are 0.
- Read latency: acceptance edge → 1 cycle ST_READ → 1 cycle ST_RENABLE. The data phase lasts 2 cycles (1 wait state).
- Write latency: acceptance edge → ST_WWAIT → ST_WRITE → ST_WENABLE. The data phase lasts 3 cycles (2 wait states).
- penable is never 1 unless pselx!=0 was set in the immediately preceding cycle with the same paddr.
- Back-to-back transfers:
  - A request accepted in ST_RENABLE/ST_WENABLE starts its setup phase the next cycle.
  - penable drops to 0 for that setup cycle; no idle cycle is inserted.
- While hready_out=0, valid, haddr, hwrite and tempselx are ignored. The AHB master holds them.
- Reset asserted mid-transfer: outputs go to reset values immediately and the transfer is abandoned.

## Test plan
- Reset:
  - Stimulus: hresetn=0 while in ST_WENABLE.
  - Response: same cycle pselx=0, penable=0, hready_out=1, paddr=0; state ST_IDLE after release.
- Single read:
  - Stimulus: valid=1, hwrite=0, haddr=0x8000_0010, tempselx=3'b001, prdata=0x19.
  - Response: cycle1 pselx=001/penable=0/hready_out=0; cycle2 penable=1/hready_out=1/hrdata=0x19; cycle3 pselx=0.
- Single write:
  - Stimulus: haddr=0x8400_0004, tempselx=3'b010, hwdata=0xDEAD_BEEF.
  - Response: ST_WWAIT, then two APB cycles with pwrite=1, paddr=0x8400_0004, pwdata=0xDEAD_BEEF; penable is 0 then 1; hready_out is 0,0,1.
- Back-to-back read-then-write:
  - Stimulus: a write request presented during ST_RENABLE.
  - Response: the next cycle is ST_WWAIT with penable=0; no ST_IDLE cycle occurs.
- Unmapped address:
  - Stimulus: valid=1, tempselx=3'b000.
  - Response: stays ST_IDLE, hready_out=1, pselx=0 for all cycles.
- Hold during wait:
  - Stimulus: change haddr while hready_out=0.
  - Response: paddr keeps the originally captured value.
